// File: rtl/com_spbram_mp_control.sv
// rtl/com_spbram_mp_control.sv - two-port (write/read) arbiter and read pipeline in front of a single-port BRAM
//
// Purpose:
//   Shares one single-port BRAM between an independent write port and read
//   port. At most one access is granted per cycle. Acks are combinational so
//   a requester sees its grant in the same cycle it presents Valid. Read data
//   comes back BRAMLatency+1 cycles after the read accept: the BRAM's own
//   latency plus one output register stage.
//
// Configuration:
//   COM_SPBRAM_RR_ARB_EN - when defined, contested cycles are arbitrated
//                          round-robin with a one-bit last-grant state;
//                          when undefined, the write port always wins.
//
// Parameters:
//   AddressWidth - BRAM address width in bits
//   DataWidth    - data width in bits (multiple of 8)
//   BRAMLatency  - BRAM read latency in cycles (1..4)
//
// Ports:
//   iClock, iReset       - rising-edge clock, synchronous active-high reset
//   iWriteAddress/Data   - write request address and data
//   iWriteStrobe         - per-byte write enables; all-zero is a legal no-op
//   iWriteValid/oWriteAck- write handshake, transfer when both high
//   iReadAddress         - read request address
//   iReadValid/oReadAck  - read handshake, transfer when both high
//   oReadData            - registered read data, held between pulses
//   oReadDataValid       - one-cycle pulse per accepted read, no backpressure
//   oBRAMAddress         - address to the BRAM
//   oBRAMWriteData       - write data to the BRAM
//   iBRAMReadData        - read data from the BRAM
//   oBRAMEn              - BRAM enable, high only on a granted cycle
//   oBRAMWEnable         - BRAM byte write enables, zero unless a write is granted

module com_spbram_mp_control #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int BRAMLatency  = 1
) (
  input  logic                      iClock,
  input  logic                      iReset,

  input  logic [AddressWidth-1:0]   iWriteAddress,
  input  logic [DataWidth-1:0]      iWriteData,
  input  logic [DataWidth/8-1:0]    iWriteStrobe,
  input  logic                      iWriteValid,
  output logic                      oWriteAck,

  input  logic [AddressWidth-1:0]   iReadAddress,
  input  logic                      iReadValid,
  output logic                      oReadAck,
  output logic [DataWidth-1:0]      oReadData,
  output logic                      oReadDataValid,

  output logic [AddressWidth-1:0]   oBRAMAddress,
  output logic [DataWidth-1:0]      oBRAMWriteData,
  input  logic [DataWidth-1:0]      iBRAMReadData,
  output logic                      oBRAMEn,
  output logic [DataWidth/8-1:0]    oBRAMWEnable
);

  localparam int StrobeWidth = DataWidth / 8;

  // writeWins decides only the contested case; an uncontested requester is
  // always granted.
  logic writeWins;
  logic writeGrant;
  logic readGrant;

`ifdef COM_SPBRAM_RR_ARB_EN
  // Round-robin: the state names which port gets the next contested cycle.
  // It only moves on contested cycles, so an uncontested burst from one port
  // does not cost the other port its turn.
  typedef enum logic {
    ArbWriteFavoured = 1'b0,
    ArbReadFavoured  = 1'b1
  } tArbState;

  tArbState arbState;
  tArbState arbStateNext;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      arbState <= ArbWriteFavoured;
    end else begin
      arbState <= arbStateNext;
    end
  end

  always_comb begin
    arbStateNext = arbState;
    writeWins    = (arbState == ArbWriteFavoured);
    if (!iReset && iWriteValid && iReadValid) begin
      arbStateNext = writeWins ? ArbReadFavoured : ArbWriteFavoured;
    end
  end
`else
  // Fixed priority: the write port wins every contested cycle.
  assign writeWins = 1'b1;
`endif

  // Grants are masked by reset so no handshake can complete while the
  // pipeline is being cleared.
  assign writeGrant = !iReset && iWriteValid && (writeWins || !iReadValid);
  assign readGrant  = !iReset && iReadValid && !(iWriteValid && writeWins);

  assign oWriteAck = writeGrant;
  assign oReadAck  = readGrant;

  // BRAM side. Write data is passed through unconditionally; it only matters
  // when oBRAMWEnable is non-zero. A write grant with a zero strobe still
  // enables the BRAM for that cycle, which is harmless and keeps the grant
  // logic uniform.
  assign oBRAMAddress   = writeGrant ? iWriteAddress : iReadAddress;
  assign oBRAMWriteData = iWriteData;
  assign oBRAMEn        = writeGrant || readGrant;
  assign oBRAMWEnable   = writeGrant ? iWriteStrobe : {StrobeWidth{1'b0}};

  // Read tracking: one bit per cycle of BRAM latency. Bit BRAMLatency-1 is
  // high in exactly the cycle the BRAM presents the data for that read, so
  // the data is captured on that edge and the valid pulse follows with it.
  logic [BRAMLatency-1:0] readPipe;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      readPipe       <= '0;
      oReadDataValid <= 1'b0;
      oReadData      <= '0;
    end else begin
      readPipe[0] <= readGrant;
      for (int i = 1; i < BRAMLatency; i++) begin
        readPipe[i] <= readPipe[i-1];
      end
      oReadDataValid <= readPipe[BRAMLatency-1];
      if (readPipe[BRAMLatency-1]) begin
        oReadData <= iBRAMReadData;
      end
    end
  end

endmodule

// File: tb/tb_com_spbram_mp_control.sv
// tb/tb_com_spbram_mp_control.sv - self-checking bench for com_spbram_mp_control at BRAMLatency 1 and 3
module tb_com_spbram_mp_control;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic iClock = 1'b0;
  always #5 iClock = ~iClock;

  logic          iReset;
  logic [AW-1:0] iWriteAddress;
  logic [DW-1:0] iWriteData;
  logic [SW-1:0] iWriteStrobe;
  logic          iWriteValid;
  logic [AW-1:0] iReadAddress;
  logic          iReadValid;

  logic          wAck1, rAck1, rdv1, en1;
  logic [DW-1:0] rd1, wd1, bramRd1;
  logic [AW-1:0] ba1;
  logic [SW-1:0] we1;

  logic          wAck3, rAck3, rdv3, en3;
  logic [DW-1:0] rd3, wd3, bramRd3;
  logic [AW-1:0] ba3;
  logic [SW-1:0] we3;

  com_spbram_mp_control #(.AddressWidth(AW), .DataWidth(DW), .BRAMLatency(1)) dut1 (
    .iClock(iClock), .iReset(iReset),
    .iWriteAddress(iWriteAddress), .iWriteData(iWriteData), .iWriteStrobe(iWriteStrobe),
    .iWriteValid(iWriteValid), .oWriteAck(wAck1),
    .iReadAddress(iReadAddress), .iReadValid(iReadValid), .oReadAck(rAck1),
    .oReadData(rd1), .oReadDataValid(rdv1),
    .oBRAMAddress(ba1), .oBRAMWriteData(wd1), .iBRAMReadData(bramRd1),
    .oBRAMEn(en1), .oBRAMWEnable(we1)
  );

  com_spbram_mp_control #(.AddressWidth(AW), .DataWidth(DW), .BRAMLatency(3)) dut3 (
    .iClock(iClock), .iReset(iReset),
    .iWriteAddress(iWriteAddress), .iWriteData(iWriteData), .iWriteStrobe(iWriteStrobe),
    .iWriteValid(iWriteValid), .oWriteAck(wAck3),
    .iReadAddress(iReadAddress), .iReadValid(iReadValid), .oReadAck(rAck3),
    .oReadData(rd3), .oReadDataValid(rdv3),
    .oBRAMAddress(ba3), .oBRAMWriteData(wd3), .iBRAMReadData(bramRd3),
    .oBRAMEn(en3), .oBRAMWEnable(we3)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge iClock) cyc <= cyc + 1;

  // BRAM models: latency 1 and latency 3 (two extra output stages)
  logic [DW-1:0] mem1   [0:255];
  logic [DW-1:0] mem3   [0:255];
  logic [DW-1:0] refMem [0:255];
  logic [DW-1:0] stA, stB;

  always @(posedge iClock) begin
    if (en1) begin
      for (int b = 0; b < SW; b++) if (we1[b]) mem1[ba1[7:0]][8*b +: 8] <= wd1[8*b +: 8];
      bramRd1 <= mem1[ba1[7:0]];
    end
    if (en3) begin
      for (int b = 0; b < SW; b++) if (we3[b]) mem3[ba3[7:0]][8*b +: 8] <= wd3[8*b +: 8];
      stA <= mem3[ba3[7:0]];
    end
    stB     <= stA;
    bramRd3 <= stB;
  end

  // Scoreboard: expected data and due cycle pushed at accept, popped at pulse
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  always @(negedge iClock) begin
    if (!iReset) begin
      if (wAck1) begin
        for (int b = 0; b < SW; b++)
          if (iWriteStrobe[b]) refMem[iWriteAddress[7:0]][8*b +: 8] = iWriteData[8*b +: 8];
      end
      if (rAck1) begin
        q1.push_back('{refMem[iReadAddress[7:0]], cyc + 2});
        q3.push_back('{refMem[iReadAddress[7:0]], cyc + 4});
      end
    end
    if (rdv1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL sb_lat1_unexpected: pulse at cycle %0d data %h, no read outstanding", cyc, rd1);
      end else begin
        e1 = q1.pop_front();
        if (rd1 !== e1.data || cyc != e1.due) begin
          fails++;
          $display("FAIL sb_lat1: got %h at cycle %0d, expected %h at cycle %0d", rd1, cyc, e1.data, e1.due);
        end
      end
    end
    if (rdv3) begin
      tests++;
      if (q3.size() == 0) begin
        fails++;
        $display("FAIL sb_lat3_unexpected: pulse at cycle %0d data %h, no read outstanding", cyc, rd3);
      end else begin
        e3 = q3.pop_front();
        if (rd3 !== e3.data || cyc != e3.due) begin
          fails++;
          $display("FAIL sb_lat3: got %h at cycle %0d, expected %h at cycle %0d", rd3, cyc, e3.data, e3.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic idleInputs();
    iWriteValid  = 1'b0;
    iReadValid   = 1'b0;
    iWriteStrobe = '0;
  endtask

  task automatic waitRdv1(output bit ok, output int c);
    ok = 1'b0;
    c  = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge iClock);
      if (rdv1) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    iReset        = 1'b1;
    iWriteAddress = 32'h8;
    iWriteData    = 32'hFFFF_FFFF;
    iWriteStrobe  = 4'hF;
    iWriteValid   = 1'b1;
    iReadAddress  = 32'h9;
    iReadValid    = 1'b1;
    repeat (3) @(posedge iClock);
    @(negedge iClock);
    tests++;
    if ({wAck1, rAck1, en1, we1} !== 7'b0 || {wAck3, rAck3, en3, we3} !== 7'b0) begin
      fails++;
      $display("FAIL reset_handshake: lat1 {wack,rack,en,we}=%b lat3=%b, expected all zero",
               {wAck1, rAck1, en1, we1}, {wAck3, rAck3, en3, we3});
    end
    tests++;
    if (rdv1 !== 1'b0 || rd1 !== 32'h0 || rdv3 !== 1'b0 || rd3 !== 32'h0) begin
      fails++;
      $display("FAIL reset_readout: rdv1=%b rd1=%h rdv3=%b rd3=%h, expected 0/0", rdv1, rd1, rdv3, rd3);
    end
    tick();
    iReset = 1'b0;
    idleInputs();
  endtask

  task automatic test_idle();
    tick();
    idleInputs();
    @(negedge iClock);
    tests++;
    if (en1 !== 1'b0 || we1 !== 4'b0 || en3 !== 1'b0 || we3 !== 4'b0) begin
      fails++;
      $display("FAIL idle_bram: en1=%b we1=%b en3=%b we3=%b, expected 0", en1, we1, en3, we3);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    int t0, c;
    tick();
    iReadAddress = 32'h10;
    iReadValid   = 1'b1;
    @(negedge iClock);
    t0 = cyc;
    tests++;
    if (rAck1 !== 1'b1 || wAck1 !== 1'b0 || en1 !== 1'b1 || we1 !== 4'b0 || ba1 !== 32'h10) begin
      fails++;
      $display("FAIL read_grant: rack=%b wack=%b en=%b we=%b addr=%h, expected 1/0/1/0/00000010",
               rAck1, wAck1, en1, we1, ba1);
    end
    tick();
    idleInputs();
    waitRdv1(ok, c);
    tests++;
    if (!ok || c - t0 != 2 || rd1 !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL read_latency1: seen=%0d latency=%0d data=%h, expected latency 2 data deadbeef", ok, c - t0, rd1);
    end
    @(negedge iClock);
    tests++;
    if (rdv1 !== 1'b0 || rd1 !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL read_hold: rdv=%b data=%h, expected 0 and held deadbeef", rdv1, rd1);
    end
    repeat (3) tick();
  endtask

  task automatic test_write_strobe();
    bit ok;
    int c;
    tick();
    iWriteAddress = 32'h4;
    iWriteData    = 32'hA5A5_A5A5;
    iWriteStrobe  = 4'b0011;
    iWriteValid   = 1'b1;
    @(negedge iClock);
    tests++;
    if (wAck1 !== 1'b1 || rAck1 !== 1'b0 || en1 !== 1'b1 || we1 !== 4'b0011 || ba1 !== 32'h4 || wd1 !== 32'hA5A5_A5A5) begin
      fails++;
      $display("FAIL write_grant: wack=%b en=%b we=%b addr=%h wdata=%h, expected 1/1/0011/00000004/a5a5a5a5",
               wAck1, en1, we1, ba1, wd1);
    end
    tick();
    iWriteData   = 32'hFFFF_FFFF;
    iWriteStrobe = 4'b0000;
    @(negedge iClock);
    tests++;
    if (wAck1 !== 1'b1 || en1 !== 1'b1 || we1 !== 4'b0) begin
      fails++;
      $display("FAIL zero_strobe: wack=%b en=%b we=%b, expected 1/1/0000", wAck1, en1, we1);
    end
    tick();
    idleInputs();
    iReadAddress = 32'h4;
    iReadValid   = 1'b1;
    @(negedge iClock);
    tests++;
    if (rAck1 !== 1'b1) begin
      fails++;
      $display("FAIL readback_ack: rack=%b, expected 1", rAck1);
    end
    tick();
    idleInputs();
    waitRdv1(ok, c);
    tests++;
    if (!ok || rd1 !== 32'h1122_A5A5) begin
      fails++;
      $display("FAIL byte_merge: seen=%0d data=%h, expected 1122a5a5", ok, rd1);
    end
    repeat (4) tick();
  endtask

  task automatic test_contention();
    logic [3:0] wv, rv, expW, expR;
    wv = '0;
    rv = '0;
`ifdef COM_SPBRAM_RR_ARB_EN
    expW = 4'b0101;
    expR = 4'b1010;
`else
    expW = 4'b1111;
    expR = 4'b0000;
`endif
    tick();
    iWriteAddress = 32'h30;
    iWriteData    = 32'h5A5A_0000;
    iWriteStrobe  = 4'hF;
    iWriteValid   = 1'b1;
    iReadAddress  = 32'h20;
    iReadValid    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClock);
      wv[i] = wAck1;
      rv[i] = rAck1;
      tests++;
      if ((wAck1 ^ rAck1) !== 1'b1) begin
        fails++;
        $display("FAIL one_grant[%0d]: wack=%b rack=%b, expected exactly one", i, wAck1, rAck1);
      end
      tick();
    end
    idleInputs();
    tests++;
    if (wv !== expW || rv !== expR) begin
      fails++;
      $display("FAIL contention: write acks %b read acks %b, expected %b / %b", wv, rv, expW, expR);
    end
    repeat (6) tick();
  endtask

  task automatic test_back_to_back();
    int t0, n, first;
    bit gap;
    logic [DW-1:0] got [0:7];
    n     = 0;
    first = -1;
    gap   = 1'b0;
    t0    = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k < 8) begin
        iReadAddress = 32'h40 + k;
        iReadValid   = 1'b1;
      end else begin
        iReadValid = 1'b0;
      end
      @(negedge iClock);
      if (k == 0) t0 = cyc;
      if (k < 8) begin
        tests++;
        if (rAck3 !== 1'b1) begin
          fails++;
          $display("FAIL b2b_ack[%0d]: rack=%b, expected 1", k, rAck3);
        end
      end
      if (rdv3) begin
        if (n == 0) first = cyc - t0;
        else if (first + n != cyc - t0) gap = 1'b1;
        if (n < 8) got[n] = rd3;
        n++;
      end
    end
    tests++;
    if (n != 8 || first != 4 || gap) begin
      fails++;
      $display("FAIL b2b_pulses: count=%0d first=%0d gap=%0d, expected 8 pulses from cycle 4 with no gap", n, first, gap);
    end
    for (int i = 0; i < 8 && i < n; i++) begin
      tests++;
      if (got[i] !== 32'h1000_0040 + i) begin
        fails++;
        $display("FAIL b2b_order[%0d]: data %h, expected %h", i, got[i], 32'h1000_0040 + i);
      end
    end
    tests++;
    if (q1.size() != 0 || q3.size() != 0) begin
      fails++;
      $display("FAIL drain: outstanding lat1=%0d lat3=%0d, expected 0/0", q1.size(), q3.size());
    end
  endtask

  task automatic test_reset_inflight();
    int pulses;
    for (int i = 0; i < 2; i++) begin
      tick();
      iReadAddress = 32'h50 + i;
      iReadValid   = 1'b1;
      @(negedge iClock);
      tests++;
      if (rAck3 !== 1'b1) begin
        fails++;
        $display("FAIL inflight_ack[%0d]: rack=%b, expected 1", i, rAck3);
      end
    end
    tick();
    idleInputs();
    iReset = 1'b1;
    tick();
    q1.delete();
    q3.delete();
    iWriteValid = 1'b1;
    iReadValid  = 1'b1;
    @(negedge iClock);
    tests++;
    if ({wAck1, rAck1, en1, we1, rdv1} !== 8'b0 || rd1 !== 32'h0 ||
        {wAck3, rAck3, en3, we3, rdv3} !== 8'b0 || rd3 !== 32'h0) begin
      fails++;
      $display("FAIL inflight_reset_outputs: lat1=%b/%h lat3=%b/%h, expected zeros",
               {wAck1, rAck1, en1, we1, rdv1}, rd1, {wAck3, rAck3, en3, we3, rdv3}, rd3);
    end
    tick();
    iReset = 1'b0;
    idleInputs();
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge iClock);
      if (rdv1 || rdv3) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL inflight_discard: %0d pulses after reset, expected 0", pulses);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i]   = 32'h1000_0000 + i;
      mem3[i]   = 32'h1000_0000 + i;
      refMem[i] = 32'h1000_0000 + i;
    end
    mem1[16] = 32'hDEAD_BEEF; mem3[16] = 32'hDEAD_BEEF; refMem[16] = 32'hDEAD_BEEF;
    mem1[4]  = 32'h1122_3344; mem3[4]  = 32'h1122_3344; refMem[4]  = 32'h1122_3344;
    iReset        = 1'b1;
    iWriteAddress = '0;
    iWriteData    = '0;
    iReadAddress  = '0;
    idleInputs();

    test_reset();
    test_idle();
    test_single_read();
    test_write_strobe();
    test_contention();
    test_back_to_back();
    test_reset_inflight();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
